// File: rtl/wb_gpio_pkg.sv
// Shared constants for the GPIO interrupt block: register map, arm FSM encoding and arm length.
package wb_gpio_pkg;

  localparam logic [2:0] GPIO_IRQ_ADR_IN      = 3'd0;
  localparam logic [2:0] GPIO_IRQ_ADR_RISE_EN = 3'd1;
  localparam logic [2:0] GPIO_IRQ_ADR_FALL_EN = 3'd2;
  localparam logic [2:0] GPIO_IRQ_ADR_PEND    = 3'd3;
  localparam logic [2:0] GPIO_IRQ_ADR_MASK    = 3'd4;
  localparam logic [2:0] GPIO_IRQ_ADR_DEB     = 3'd5;

  typedef enum logic {
    ARM_S = 1'b0,
    RUN_S = 1'b1
  } arm_state_e;

  // Clocks spent in ARM after reset before edges may set pending bits.
  localparam int unsigned ARM_CNT = 3;

endpackage

// File: rtl/wb_gpio_irq_if.sv
// Wishbone classic slave bundle for wb_gpio_irq; the bus master drives the _i members.
interface wb_gpio_irq_if #(
  parameter int unsigned wb_dat_width = 16,
  parameter int unsigned wb_adr_width = 14
);
  logic [wb_adr_width-1:0] wb_adr_i;
  logic [wb_dat_width-1:0] wb_dat_i;
  logic                    wb_we_i;
  logic                    wb_cyc_i;
  logic                    wb_stb_i;
  logic                    wb_ack_o;
  logic [wb_dat_width-1:0] wb_dat_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_ack_o, wb_dat_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_ack_o, wb_dat_o
  );
endinterface

// File: rtl/gpio_debounce.sv
// Per-pin 3-sample glitch filter: f_o follows d_i once three consecutive tick samples agree.
// Only instantiated when WB_GPIO_IRQ_DEBOUNCE_EN is defined; adds 3..4 ticks of latency.
module gpio_debounce (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic d_i,
  output logic f_o
);
  logic [1:0] hist_q, hist_d;
  logic       f_q, f_d;

  always_comb begin
    hist_d = hist_q;
    f_d    = f_q;
    if (tick_i) begin
      hist_d = {hist_q[0], d_i};
      // Current sample plus the two previous ones must all agree.
      if ((d_i && hist_q == 2'b11) || (!d_i && hist_q == 2'b00)) begin
        f_d = d_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hist_q <= '0;
      f_q    <= 1'b0;
    end else begin
      hist_q <= hist_d;
      f_q    <= f_d;
    end
  end

  assign f_o = f_q;
endmodule

// File: rtl/wb_gpio_irq.sv
// Wishbone slave turning enabled GPIO edges into W1C pending bits and a registered level irq.
// Pin to irq 3 clocks (plus 3..4 ticks with WB_GPIO_IRQ_DEBOUNCE_EN); ack 1 clock after accept, every 2nd cycle if held.
module wb_gpio_irq
  import wb_gpio_pkg::*;
#(
  parameter int unsigned gpio_width        = 8,
  parameter int unsigned wb_dat_width      = 16,
  parameter int unsigned wb_adr_width      = 14,
  parameter logic [15:0] deb_div_reset_val = 16'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  wb_gpio_irq_if.slave          wb,
  input  logic [gpio_width-1:0] gpio_i,
  output logic                  irq
);
  localparam int unsigned GW = gpio_width;
  localparam int unsigned DW = wb_dat_width;

  logic [GW-1:0] sync1_q, sync2_q, prev_q, f;
  logic [GW-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
  logic [GW-1:0] pend_q, pend_d, mask_q, mask_d;
  logic [GW-1:0] rise, fall, clr, wr_val;
  arm_state_e    state_q, state_d;
  logic [1:0]    arm_cnt_q, arm_cnt_d;
  logic          ack_q, ack_d, irq_q, irq_d;
  logic [DW-1:0] dat_q, dat_d, rd_val;
  logic [2:0]    adr;
  logic          acc, wr_acc;
  logic [15:0]   deb_div_rd;

  logic [wb_adr_width-1:0] unused_adr;
  logic [DW-1:0]           unused_dat;
  assign unused_adr = wb.wb_adr_i;
  assign unused_dat = wb.wb_dat_i;

  assign adr    = wb.wb_adr_i[2:0];
  assign acc    = wb.wb_stb_i & wb.wb_cyc_i & ~ack_q;
  assign wr_acc = acc & wb.wb_we_i;
  assign wr_val = wb.wb_dat_i[GW-1:0];

`ifdef WB_GPIO_IRQ_DEBOUNCE_EN
  logic [15:0] deb_div_q, deb_div_d, pre_q, pre_d;
  logic        tick;

  // Compare with >= so lowering DEB_DIV below the running count cannot stall the prescaler.
  assign tick      = (pre_q >= deb_div_q);
  assign pre_d     = tick ? 16'd0 : pre_q + 16'd1;
  assign deb_div_d = (wr_acc && adr == GPIO_IRQ_ADR_DEB) ? wb.wb_dat_i[15:0] : deb_div_q;
  assign deb_div_rd = deb_div_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      deb_div_q <= deb_div_reset_val;
      pre_q     <= '0;
    end else begin
      deb_div_q <= deb_div_d;
      pre_q     <= pre_d;
    end
  end

  for (genvar i = 0; i < GW; i++) begin : g_deb
    gpio_debounce u_deb (
      .clk    (clk),
      .rst    (rst),
      .tick_i (tick),
      .d_i    (sync2_q[i]),
      .f_o    (f[i])
    );
  end
`else
  logic [15:0] unused_deb;
  assign unused_deb = deb_div_reset_val;
  assign deb_div_rd = 16'd0;
  assign f          = sync2_q;
`endif

  always_comb begin
    rd_val = '0;
    case (adr)
      GPIO_IRQ_ADR_IN:      rd_val[GW-1:0] = f;
      GPIO_IRQ_ADR_RISE_EN: rd_val[GW-1:0] = rise_en_q;
      GPIO_IRQ_ADR_FALL_EN: rd_val[GW-1:0] = fall_en_q;
      GPIO_IRQ_ADR_PEND:    rd_val[GW-1:0] = pend_q;
      GPIO_IRQ_ADR_MASK:    rd_val[GW-1:0] = mask_q;
      GPIO_IRQ_ADR_DEB:     rd_val[15:0]   = deb_div_rd;
      default:              rd_val         = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    if (state_q == ARM_S) begin
      arm_cnt_d = arm_cnt_q + 2'd1;
      if (arm_cnt_q == 2'(ARM_CNT - 1)) begin
        state_d = RUN_S;
      end
    end
  end

  // Edges are ignored while arming so pin levels present at reset never raise pending bits.
  assign rise = (state_q == RUN_S) ? (f & ~prev_q & rise_en_q) : '0;
  assign fall = (state_q == RUN_S) ? (~f & prev_q & fall_en_q) : '0;
  assign clr  = (wr_acc && adr == GPIO_IRQ_ADR_PEND) ? wr_val : '0;

  always_comb begin
    pend_d    = (pend_q & ~clr) | rise | fall;
    rise_en_d = (wr_acc && adr == GPIO_IRQ_ADR_RISE_EN) ? wr_val : rise_en_q;
    fall_en_d = (wr_acc && adr == GPIO_IRQ_ADR_FALL_EN) ? wr_val : fall_en_q;
    mask_d    = (wr_acc && adr == GPIO_IRQ_ADR_MASK)    ? wr_val : mask_q;
    ack_d     = acc;
    dat_d     = (acc && !wb.wb_we_i) ? rd_val : dat_q;
    irq_d     = |(pend_q & mask_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
      mask_q    <= '0;
      state_q   <= ARM_S;
      arm_cnt_q <= '0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      sync1_q   <= gpio_i;
      sync2_q   <= sync1_q;
      prev_q    <= f;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      state_q   <= state_d;
      arm_cnt_q <= arm_cnt_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      irq_q     <= irq_d;
    end
  end

  assign wb.wb_ack_o = wb.wb_stb_i & wb.wb_cyc_i & ack_q;
  assign wb.wb_dat_o = dat_q;
  assign irq         = irq_q;
endmodule

// File: tb/tb_wb_gpio_irq.sv
// Randomized bench for wb_gpio_irq: a pin-history reference model is compared every cycle, plus directed literal checks.
module tb_wb_gpio_irq;
  localparam int GW = 8;
  localparam int DW = 16;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [GW-1:0] gpio_i = '0;
  logic          irq;

  wb_gpio_irq_if #(.wb_dat_width(DW), .wb_adr_width(AW)) wb ();

  wb_gpio_irq #(
    .gpio_width        (GW),
    .wb_dat_width      (DW),
    .wb_adr_width      (AW),
    .deb_div_reset_val (16'd0)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wb     (wb),
    .gpio_i (gpio_i),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pin level seen at each edge (0 while in reset) and the reset flag per edge.
  bit [GW-1:0]   pin_at [0:8191];
  bit            rst_at [0:8191];
  int            k = 2;
  int            armed = 0;
  logic [GW-1:0] m_rise = '0, m_fall = '0, m_pend = '0, m_mask = '0;
  logic [15:0]   m_deb = '0;
  logic [DW-1:0] m_dat = '0;
  logic          m_ackq = 1'b0, m_irq = 1'b0;

  // Filtered level after edge e: the pin as it was one edge earlier, cleared by reset.
  function automatic logic [GW-1:0] filt(input int e);
    return rst_at[e] ? GW'(pin_at[e-1]) : '0;
  endfunction

  function automatic logic [DW-1:0] reg_view(input logic [2:0] a, input logic [GW-1:0] fin);
    logic [DW-1:0] v;
    v = '0;
    case (a)
      3'd0: v[GW-1:0] = fin;
      3'd1: v[GW-1:0] = m_rise;
      3'd2: v[GW-1:0] = m_fall;
      3'd3: v[GW-1:0] = m_pend;
      3'd4: v[GW-1:0] = m_mask;
`ifdef WB_GPIO_IRQ_DEBOUNCE_EN
      3'd5: v[15:0]   = m_deb;
`endif
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic model_step();
    logic          acc;
    logic [2:0]    a;
    logic [GW-1:0] wv, clr, ev, f1, f2;
    logic [DW-1:0] rv;
    k++;
    rst_at[k] = rst;
    pin_at[k] = rst ? gpio_i : '0;
    if (!rst) begin
      m_rise = '0; m_fall = '0; m_pend = '0; m_mask = '0; m_deb = '0;
      m_dat = '0; m_ackq = 1'b0; m_irq = 1'b0; armed = 0;
      return;
    end
    a   = wb.wb_adr_i[2:0];
    wv  = wb.wb_dat_i[GW-1:0];
    acc = wb.wb_stb_i && wb.wb_cyc_i && !m_ackq;
    f1  = filt(k - 1);
    f2  = filt(k - 2);
    ev  = (armed >= 3) ? ((f1 & ~f2 & m_rise) | (~f1 & f2 & m_fall)) : '0;
    clr = (acc && wb.wb_we_i && a == 3'd3) ? wv : '0;
    rv  = reg_view(a, f1);
    m_irq  = |(m_pend & m_mask);
    m_pend = (m_pend & ~clr) | ev;
    if (acc && !wb.wb_we_i) m_dat = rv;
    if (acc && wb.wb_we_i) begin
      case (a)
        3'd1: m_rise = wv;
        3'd2: m_fall = wv;
        3'd4: m_mask = wv;
`ifdef WB_GPIO_IRQ_DEBOUNCE_EN
        3'd5: m_deb = wb.wb_dat_i[15:0];
`endif
        default: ;
      endcase
    end
    m_ackq = acc;
    armed++;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("ack", wb.wb_ack_o, wb.wb_stb_i & wb.wb_cyc_i & m_ackq);
`ifndef WB_GPIO_IRQ_DEBOUNCE_EN
      check("rdata", wb.wb_dat_o, m_dat);
      check("irq", irq, m_irq);
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after a clock edge; returns just after the edge whose ack it observed.
  task automatic bus(input logic we, input logic [2:0] a, input logic [DW-1:0] d, output logic [DW-1:0] q);
    int n;
    n = 0;
    wb.wb_adr_i = AW'(a);
    wb.wb_dat_i = d;
    wb.wb_we_i  = we;
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    do begin
      tick(1);
      n++;
    end while (!wb.wb_ack_o && n < 8);
    check("bus_ack", wb.wb_ack_o, 1);
    q = wb.wb_dat_o;
    wb.wb_stb_i = 1'b0;
    wb.wb_cyc_i = 1'b0;
    wb.wb_we_i  = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] q;
    bus(1'b1, a, d, q);
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [DW-1:0] exp);
    logic [DW-1:0] q;
    bus(1'b0, a, '0, q);
    check(name, q, exp);
  endtask

  initial begin
    logic [3:0] ack_pat;
    wb.wb_adr_i = '0; wb.wb_dat_i = '0; wb.wb_we_i = 1'b0;
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;

    // Reset with pins high and a RISE_EN=FF write already on the bus.
    rst = 1'b0;
    gpio_i = 8'hFF;
    wb.wb_adr_i = AW'(1); wb.wb_dat_i = 16'h00FF; wb.wb_we_i = 1'b1;
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
    tick(1);
    chk_en = 1'b1;
    tick(3);
    check("reset_ack", wb.wb_ack_o, 0);
    check("reset_dat", wb.wb_dat_o, 0);
    check("reset_irq", irq, 0);
    rst = 1'b1;
    tick(1);
    check("first_write_ack", wb.wb_ack_o, 1);
    wb.wb_stb_i = 1'b0; wb.wb_cyc_i = 1'b0; wb.wb_we_i = 1'b0;
    tick(10);
    rd_chk("rise_en_ff", 3'd1, 16'h00FF);
`ifndef WB_GPIO_IRQ_DEBOUNCE_EN
    rd_chk("pend_after_arm", 3'd3, 16'h0000);
`endif
    check("irq_after_arm", irq, 0);

`ifndef WB_GPIO_IRQ_DEBOUNCE_EN
    // Rising edge on pin 0, sampled at edge N.
    gpio_i = 8'h00;
    tick(6);
    wr(3'd1, 16'h0001);
    wr(3'd4, 16'h0001);
    rd_chk("pend_idle", 3'd3, 16'h0000);
    gpio_i = 8'h01;
    tick(2);
    check("irq_n1", irq, 0);
    tick(1);
    check("irq_n2", irq, 0);
    tick(1);
    check("irq_n3", irq, 1);
    rd_chk("pend_rise0", 3'd3, 16'h0001);
    rd_chk("in_level", 3'd0, 16'h0001);

    // W1C landing on the same edge as a fresh rise: the set wins.
    gpio_i = 8'h00;
    tick(6);
    gpio_i = 8'h01;
    tick(2);
    wr(3'd3, 16'h0001);
    check("irq_set_wins", irq, 1);
    tick(2);
    check("irq_still_set", irq, 1);
    rd_chk("pend_set_wins", 3'd3, 16'h0001);
    wr(3'd3, 16'h0001);
    check("irq_clr_w", irq, 1);
    tick(1);
    check("irq_clr_w1", irq, 0);
    rd_chk("pend_cleared", 3'd3, 16'h0000);

    // Falling edge on pin 7 with the irq masked, then unmask.
    wr(3'd2, 16'h0080);
    wr(3'd4, 16'h0000);
    gpio_i = 8'h81;
    tick(6);
    gpio_i = 8'h01;
    tick(6);
    rd_chk("pend_fall7", 3'd3, 16'h0080);
    check("irq_masked", irq, 0);
    wr(3'd4, 16'h0080);
    check("irq_mask_w", irq, 0);
    tick(1);
    check("irq_mask_w1", irq, 1);
`endif

    // Held strobe on an unmapped address: ack toggles, data reads 0.
    ack_pat = 4'b0101;
    wb.wb_adr_i = AW'(6); wb.wb_we_i = 1'b0; wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("held_ack", wb.wb_ack_o, ack_pat[i]);
      check("held_dat", wb.wb_dat_o, 0);
    end
    wb.wb_stb_i = 1'b0; wb.wb_cyc_i = 1'b0;
    tick(1);

    wr(3'd5, 16'h0003);
`ifdef WB_GPIO_IRQ_DEBOUNCE_EN
    rd_chk("deb_div", 3'd5, 16'h0003);
    gpio_i = 8'h00;
    wr(3'd1, 16'h0001);
    wr(3'd2, 16'h0000);
    tick(40);
    wr(3'd3, 16'h00FF);
    rd_chk("deb_in_base", 3'd0, 16'h0000);
    gpio_i = 8'h01;
    tick(5);
    gpio_i = 8'h00;
    tick(30);
    rd_chk("deb_glitch_in", 3'd0, 16'h0000);
    rd_chk("deb_glitch_pend", 3'd3, 16'h0000);
    gpio_i = 8'h01;
    tick(20);
    rd_chk("deb_hold_in", 3'd0, 16'h0001);
    rd_chk("deb_hold_pend", 3'd3, 16'h0001);
`else
    rd_chk("deb_div_absent", 3'd5, 16'h0000);
`endif

    // Random pins, bus traffic (held strobes, stray address bits) and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) gpio_i = GW'($urandom);
      rst = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 2) == 0) begin
        wb.wb_stb_i = ($urandom_range(0, 1) == 1);
        wb.wb_cyc_i = ($urandom_range(0, 4) != 0);
        wb.wb_we_i  = ($urandom_range(0, 1) == 1);
        wb.wb_adr_i = AW'($urandom);
        wb.wb_dat_i = DW'($urandom);
      end
      tick(1);
    end
    rst = 1'b1;
    wb.wb_stb_i = 1'b0; wb.wb_cyc_i = 1'b0;
    tick(3);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
